// File: rtl/arbitro_mux_rr_pkg.sv
// Shared types and constants for the two-lane round-robin mux scheduler.
package arbitro_mux_rr_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_e;

endpackage

// File: rtl/arbitro_mux_rr_if.sv
// Lane-side and downstream-side signals of the scheduler; master = scheduler, slave = FIFO environment.
interface arbitro_mux_rr_if #(
  parameter int DATA_W = arbitro_mux_rr_pkg::DATA_W_DEF
);
  logic              empty0;
  logic              empty1;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic              almost_full;
  logic              pop0;
  logic              pop1;
  logic              selector;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    input  empty0, empty1, data_in0, data_in1, almost_full,
    output pop0, pop1, selector, data_out, valid_out
  );

  modport slave (
    output empty0, empty1, data_in0, data_in1, almost_full,
    input  pop0, pop1, selector, data_out, valid_out
  );
endinterface

// File: rtl/arbitro_mux_rr_arb_pick.sv
// Combinational next-lane chooser; ARB_STRICT_PRIORITY_EN swaps round-robin for lane-0 strict priority.
module arb_pick
  import arbitro_mux_rr_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,  // lane that was served last (the current lane while serving)
  output logic grant,
  output logic grant_valid,
  output logic preempt      // lane 0 must take over from lane 1 right now
);

  assign grant_valid = req0 | req1;

`ifdef ARB_STRICT_PRIORITY_EN
  assign grant   = (req0 || !req1) ? LANE0 : LANE1;
  assign preempt = req0 && (last_grant == LANE1);
`else
  // The lane that did not go last wins a tie.
  assign grant   = (req0 && (!req1 || last_grant == LANE1)) ? LANE0 : LANE1;
  assign preempt = 1'b0;
`endif

endmodule

// File: rtl/arbitro_mux_rr.sv
// Round-robin scheduler popping two show-ahead lane FIFOs into one registered mux output.
// Optional macro ARB_STRICT_PRIORITY_EN gives lane 0 strict priority (handled inside arb_pick).
module arbitro_mux_rr
  import arbitro_mux_rr_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 4
) (
  input logic               clk,
  input logic               reset_L,
  arbitro_mux_rr_if.master  bus
);

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_e            state, state_nxt;
  logic [3:0]        burst_cnt, burst_cnt_nxt;
  logic              last_grant, last_grant_nxt;
  logic              selector_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;

  logic req0, req1, serving, cur_lane, cur_req, pop;
  logic pick_last, pick_grant, pick_valid, pick_preempt;

  assign req0     = !bus.empty0;
  assign req1     = !bus.empty1;
  assign serving  = (state == SERVE0) || (state == SERVE1);
  assign cur_lane = (state == SERVE1) ? LANE1 : LANE0;
  assign cur_req  = (cur_lane == LANE1) ? req1 : req0;
  assign pop      = reset_L && serving && cur_req && !bus.almost_full;

  assign bus.pop0 = pop && (cur_lane == LANE0);
  assign bus.pop1 = pop && (cur_lane == LANE1);

  // While serving, the chooser sees the current lane as "last" so a switch favours the other lane.
  assign pick_last = serving ? cur_lane : last_grant;

  arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (pick_last),
    .grant       (pick_grant),
    .grant_valid (pick_valid),
    .preempt     (pick_preempt)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    selector_nxt   = bus.selector;
    data_nxt       = bus.data_out;
    valid_nxt      = 1'b0;

    if (!serving) begin
      if (pick_valid) begin
        state_nxt     = (pick_grant == LANE1) ? SERVE1 : SERVE0;
        burst_cnt_nxt = '0;
        selector_nxt  = pick_grant;
      end
    end else begin
      if (pop) begin
        data_nxt       = (cur_lane == LANE1) ? bus.data_in1 : bus.data_in0;
        valid_nxt      = 1'b1;
        last_grant_nxt = cur_lane;
        burst_cnt_nxt  = burst_cnt + 4'd1;
      end
      if ((pop && burst_cnt == BURST_LAST) || !cur_req || pick_preempt) begin
        burst_cnt_nxt = '0;
        if (!pick_valid) begin
          state_nxt = IDLE;
        end else begin
          state_nxt    = (pick_grant == LANE1) ? SERVE1 : SERVE0;
          selector_nxt = pick_grant;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state         <= IDLE;
      burst_cnt     <= '0;
      last_grant    <= LANE1;
      bus.selector  <= LANE0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      burst_cnt     <= burst_cnt_nxt;
      last_grant    <= last_grant_nxt;
      bus.selector  <= selector_nxt;
      bus.data_out  <= data_nxt;
      bus.valid_out <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_mux_rr.sv
// Self-checking bench for arbitro_mux_rr: queue-based lane FIFOs, behavioural scheduler model, directed + random phases.
module tb_arbitro_mux_rr;

  localparam int DW = 4;
  localparam int BM = 4;
`ifdef ARB_STRICT_PRIORITY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  arbitro_mux_rr_if #(.DATA_W(DW)) bus ();

  arbitro_mux_rr #(.DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Lane FIFOs as queues; head is element 0.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] out_log[$];

  // Behavioural model: lane being served (-1 = none), pops taken in this burst.
  int            m_lane;
  int            m_cnt;
  int            m_last;
  logic          m_sel;
  logic [DW-1:0] m_dout;
  logic          m_vout;
  logic          exp_pop0, exp_pop1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which lane should be served next, given the lane that went last.
  function automatic int pick(input bit r0, input bit r1, input int last);
    bit r_other, r_last;
    if (STRICT) return r0 ? 0 : (r1 ? 1 : -1);
    r_other = (last == 1) ? r0 : r1;
    r_last  = (last == 1) ? r1 : r0;
    if (r_other) return 1 - last;
    if (r_last)  return last;
    return -1;
  endfunction

  task automatic model_step(input bit rst_n, input bit r0, input bit r1, input bit af,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int  nl;
    bit  rn, popd, pre;
    if (!rst_n) begin
      m_lane = -1; m_cnt = 0; m_last = 1;
      m_sel = 1'b0; m_dout = '0; m_vout = 1'b0;
    end else if (m_lane < 0) begin
      m_vout = 1'b0;
      nl = pick(r0, r1, m_last);
      if (nl >= 0) begin
        m_lane = nl; m_cnt = 0; m_sel = nl[0];
      end
    end else begin
      rn   = (m_lane == 1) ? r1 : r0;
      popd = rn && !af;
      m_vout = popd;
      if (popd) begin
        m_dout = (m_lane == 1) ? d1 : d0;
        m_last = m_lane;
        m_cnt++;
      end
      pre = STRICT && m_lane == 1 && r0;
      if ((popd && m_cnt == BM) || !rn || pre) begin
        m_cnt = 0;
        nl = pick(r0, r1, m_lane);
        if (nl < 0) m_lane = -1;
        else begin
          m_lane = nl; m_sel = nl[0];
        end
      end
    end
  endtask

  // One clock: present inputs from the queues, let the edge happen, advance model and FIFOs.
  task automatic cycle(input bit rst_v, input bit af_v);
    reset_L         = rst_v;
    bus.almost_full = af_v;
    bus.empty0      = (q0.size() == 0);
    bus.empty1      = (q1.size() == 0);
    bus.data_in0    = (q0.size() != 0) ? q0[0] : '0;
    bus.data_in1    = (q1.size() != 0) ? q1[0] : '0;
    exp_pop0 = rst_v && !af_v && m_lane == 0 && q0.size() != 0;
    exp_pop1 = rst_v && !af_v && m_lane == 1 && q1.size() != 0;
    @(posedge clk);
    #1;
    model_step(rst_v, !bus.empty0, !bus.empty1, af_v, bus.data_in0, bus.data_in1);
    if (exp_pop0) void'(q0.pop_front());
    if (exp_pop1) void'(q1.pop_front());
  endtask

  task automatic restart();
    q0.delete(); q1.delete();
    cycle(1'b0, 1'b0);
    out_log.delete();
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
    check({name, "_len"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check($sformatf("%s_w%0d", name, i), out_log[i], exp[i]);
  endtask

  // Single compare process: DUT against model, every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pop0",      bus.pop0,      exp_pop0);
      check("pop1",      bus.pop1,      exp_pop1);
      check("selector",  bus.selector,  m_sel);
      check("valid_out", bus.valid_out, m_vout);
      check("data_out",  bus.data_out,  m_dout);
      if (bus.valid_out === 1'b1) out_log.push_back(bus.data_out);
    end
  end

  initial begin
    logic [DW-1:0] exp_w[$];
    bit reached;

    // Reset held two cycles with both lanes loaded.
    q0 = '{4'h1, 4'h2}; q1 = '{4'h9};
    cycle(1'b0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0);
    check("rst_pop0", bus.pop0, 1'b0);
    check("rst_pop1", bus.pop1, 1'b0);
    check("rst_sel",  bus.selector, 1'b0);
    check("rst_vout", bus.valid_out, 1'b0);
    check("rst_dout", bus.data_out, 4'h0);

    // Lane 0 only, three words.
    restart();
    q0 = '{4'hA, 4'hB, 4'hC};
    repeat (10) cycle(1'b1, 1'b0);
    exp_w = '{4'hA, 4'hB, 4'hC};
    check_log("lane0_only", exp_w);
    check("lane0_only_idle", m_lane, -1);

    // Both lanes, six words each: bursts of 4, 4, then the remaining 2 and 2.
    restart();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(4'(i)); q1.push_back(4'(8 + i));
    end
    repeat (30) cycle(1'b1, 1'b0);
`ifdef ARB_STRICT_PRIORITY_EN
    exp_w = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
`else
    exp_w = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'hC, 4'hD};
`endif
    check_log("both_lanes", exp_w);

    // almost_full for three cycles after two pops of the lane-0 burst.
    restart();
    for (int i = 0; i < 6; i++) q0.push_back(4'(i));
    for (int i = 0; i < 4; i++) q1.push_back(4'(8 + i));
    repeat (3) cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      check($sformatf("af_pop0_%0d", i), bus.pop0, 1'b0);
      check($sformatf("af_vout_%0d", i), bus.valid_out, 1'b0);
    end
    repeat (20) cycle(1'b1, 1'b0);
`ifdef ARB_STRICT_PRIORITY_EN
    exp_w = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
`else
    exp_w = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5};
`endif
    check_log("af_hold", exp_w);

    // Reset while lane 1 is being served; lane 0 must win afterwards.
    restart();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(4'(i)); q1.push_back(4'(8 + i));
    end
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      cycle(1'b1, 1'b0);
      reached = (bus.selector === 1'b1);
    end
    check("midrst_reach_serve1", reached, 1'b1);
    cycle(1'b0, 1'b0);
    check("midrst_sel",  bus.selector, 1'b0);
    check("midrst_vout", bus.valid_out, 1'b0);
    check("midrst_pop1", bus.pop1, 1'b0);
    cycle(1'b1, 1'b0);
    check("midrst_first_pop0", bus.pop0, 1'b1);
    check("midrst_first_pop1", bus.pop1, 1'b0);
    repeat (20) cycle(1'b1, 1'b0);

`ifdef ARB_STRICT_PRIORITY_EN
    // Lane 1 bursting when lane 0 fills: one more lane-1 pop, then lane 0 drains fully.
    restart();
    for (int i = 0; i < 6; i++) q1.push_back(4'(8 + i));
    repeat (3) cycle(1'b1, 1'b0);
    q0 = '{4'h0, 4'h1, 4'h2};
    repeat (20) cycle(1'b1, 1'b0);
    exp_w = '{4'h8, 4'h9, 4'hA, 4'h0, 4'h1, 4'h2, 4'hB, 4'hC, 4'hD};
    check_log("strict_preempt", exp_w);
`endif

    // Randomized traffic with backpressure and occasional reset.
    restart();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(4'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(4'($urandom));
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 4) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_mux_rr.md
Name: arbitro_mux_rr

Overview:
- Round-robin scheduler that shares the 4-bit, two-input lane mux between two show-ahead FIFOs (lane 0, lane 1).
- Decides which lane is served and pops the served FIFO.
- Drives the mux selector and registers the muxed word and valid bit toward the downstream FIFO.
- Sits between the per-lane input FIFOs and the single output FIFO in the Phy path.

Parameters:
- DATA_W, 4: width of lane data words.
- BURST_MAX, 4: maximum consecutive pops granted to one lane before the grant is offered to the other lane (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  synchronous active-low reset, sampled on posedge clk.
- empty0  input  1  lane 0 FIFO empty.
- empty1  input  1  lane 1 FIFO empty.
- data_in0  input  DATA_W  lane 0 FIFO head word, valid while empty0=0.
- data_in1  input  DATA_W  lane 1 FIFO head word, valid while empty1=0.
- almost_full  input  1  downstream FIFO almost full; blocks further pops.
- pop0  output  1  combinational pop strobe to lane 0 FIFO.
- pop1  output  1  combinational pop strobe to lane 1 FIFO.
- selector  output  1  registered mux select: 0 = lane 0, 1 = lane 1.
- data_out  output  DATA_W  registered muxed word.
- valid_out  output  1  registered; 1 for exactly one cycle per popped word (downstream push).

Behaviour:
- Reset: clk edge with reset_L=0 sets state=IDLE, selector=0, data_out=0, valid_out=0, burst_cnt=0, last_grant=1 (lane 0 wins first). pop0/pop1 are 0 throughout reset. Reset mid-burst discards the burst; no pop occurs in the reset cycle.
- Definitions: reqN = !emptyN.
- States:
  - IDLE: no pops.
    - req0 && (!req1 || last_grant==1): next state SERVE0.
    - else if req1: next state SERVE1.
    - else: stay in IDLE.
    - On entry to either SERVE state: burst_cnt=0; selector updates at the same edge.
  - SERVE0 / SERVE1: popN = reqN && !almost_full. At most one of pop0/pop1 is ever high.
- Per pop edge: data_out <= data_inN, valid_out <= 1, burst_cnt++, last_grant <= N. Latency: pop cycle to valid_out is 1 cycle.
- Any non-pop edge: valid_out <= 0; data_out holds.
- almost_full=1 in a SERVE state: no pop; state and burst_cnt hold.
- Switch rule, evaluated at a pop edge, or at any SERVE edge where reqN=0:
  - If the burst ended (burst_cnt reached BURST_MAX-1 on this pop) or reqN=0:
    - Other lane requesting: go directly to SERVE(other), burst_cnt=0, selector flips. No idle bubble.
    - Else if reqN=1 (burst limit only): stay, burst_cnt=0.
    - Else: go to IDLE; selector holds its last value.
  - Otherwise: stay.
- Never pops an empty FIFO; pops are qualified combinationally by emptyN.
- burst_cnt width: 4 bits, no wrap beyond BURST_MAX-1.

Optional Feature:
- Macro: ARB_STRICT_PRIORITY_EN.
- Defined:
  - Lane 0 has strict priority: in IDLE, req0 always wins.
  - In SERVE1, any edge with req0=1 after a pop (or while almost_full=1) moves to SERVE0.
  - Lane 0 ignores BURST_MAX and is served until empty0.
  - Lane 1 is served only while lane 0 is empty.
- Undefined: round-robin with the BURST_MAX rule above.

Decomposition:
- Shared include/package holds:
  - State encodings: IDLE=2'b00, SERVE0=2'b01, SERVE1=2'b10.
  - DATA_W default.
  - Lane index constants LANE0=0, LANE1=1.
- One natural sub-module, arb_pick: combinational next-lane chooser (inputs req0, req1, last_grant; output grant lane plus a valid flag). Reused by IDLE entry and the switch rule; the macro alters only this sub-module.

Test Plan:
1. Reset: hold reset_L=0 for 2 cycles with empty0=empty1=0 -> pop0=pop1=0, selector=0, valid_out=0, data_out=0.
2. Lane 0 only: load 3 words (0xA, 0xB, 0xC), BURST_MAX=4 -> after IDLE cycle, pop0 high 3 consecutive cycles; valid_out 3 cycles one cycle later with data 0xA, 0xB, 0xC; then return to IDLE.
3. Both lanes loaded with 6 words each, BURST_MAX=4 -> 4 lane-0 words, then 4 lane-1 with no bubble, then 2 lane-0, then 2 lane-1. selector toggles at each switch edge.
4. almost_full asserted for 3 cycles mid-burst at burst_cnt=2 -> no pops and no valid_out during those cycles; burst resumes; exactly 2 more lane-0 pops before switching.
5. reset_L=0 for one cycle during SERVE1 -> next cycle state IDLE, selector=0, valid_out=0; lane 0 wins if both lanes are requesting.
6. ARB_STRICT_PRIORITY_EN defined: lane 1 bursting, lane 0 becomes non-empty -> at most one more lane-1 pop, then selector=0 and lane 0 drained completely before lane 1 resumes.
